// File: rtl/square_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : square_shift_add
// Purpose  : Sequential unsigned squarer. Computes result = x*x by iterative
//            shift-and-add, consuming one multiplier bit per clock.
// Ports    : clk     - rising-edge clock
//            rst_n   - asynchronous active-low reset
//            start   - request, sampled only while idle
//            x       - unsigned operand (WIDTH bits), captured on accept
//            busy    - high while a computation is in progress
//            done    - one-cycle pulse when result is updated
//            result  - last completed square (2*WIDTH bits), held
// Options  : SQUARE_EARLY_EXIT_EN - finish as soon as no multiplier bits
//            remain set; result value is unchanged, latency shortens.
// Revision : 1.0 - initial release
// ============================================================================
module square_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               last_iter;
  logic               accept;

  // Partial product for the current multiplier bit.
  assign acc_next    = acc + (mplier[0] ? mcand : '0);
  assign mplier_next = mplier >> 1;

`ifdef SQUARE_EARLY_EXIT_EN
  // Once the shifted multiplier is empty, remaining iterations add nothing.
  assign last_iter = (count == LAST_COUNT) || (mplier_next == '0);
`else
  assign last_iter = (count == LAST_COUNT);
`endif

  assign accept = (state == IDLE) && start;

  // busy comes straight from the state register, so no input reaches it
  // combinationally.
  assign busy = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, x};
        mplier <= x;
        acc    <= '0;
        count  <= '0;
      end else if (state == CALC) begin
        mcand  <= mcand << 1;
        mplier <= mplier_next;
        acc    <= acc_next;
        count  <= count + 1'b1;
        if (last_iter) begin
          result <= acc_next;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_square_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_shift_add
// Purpose  : Self-checking bench for square_shift_add (WIDTH=16). Directed
//            vectors with hand-computed squares and latencies, plus a random
//            operand sweep checked against x*x.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_shift_add;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   x;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int total = 0;
  int bad   = 0;

  square_shift_add #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycles from accepting edge to done pulse.
  function automatic int exp_lat(input logic [W-1:0] v);
`ifdef SQUARE_EARLY_EXIT_EN
    int m;
    m = 0;
    for (int i = 0; i < W; i++) if (v[i]) m = i;
    return m + 1;
`else
    return W;
`endif
  endfunction

  task automatic run_one(input logic [W-1:0] xv, input string tag);
    logic [2*W-1:0] prev;
    int n;
    bit got;
    x     = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    x     = ~xv;                  // must not disturb the computation
    check({tag, "_busy0"}, busy, 1);
    prev = result;
    n    = 0;
    got  = 0;
    while (!got && n < 3 * W) begin
      tick();
      n++;
      if (done) got = 1;
      else begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_hold"}, result, prev);
      end
    end
    check({tag, "_lat"}, n, exp_lat(xv));
    check({tag, "_res"}, result, 64'(xv) * 64'(xv));
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_dpulse"}, done, 0);
  endtask

  initial begin
    int ndone;
    int last_t;
    int per;
    logic [W-1:0] rv;

    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    run_one(16'hFFFF, "ffff");
    check("ffff_val", result, 64'hFFFE0001);
    run_one(16'd3, "x3");
    check("x3_val", result, 9);
    run_one(16'd0, "x0");
    check("x0_val", result, 0);

    // Second start during CALC is ignored.
    x     = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
`ifdef SQUARE_EARLY_EXIT_EN
      if (c == 2) begin x = 16'd7; start = 1'b1; end
`else
      if (c == 4) begin x = 16'd7; start = 1'b1; end
`endif
      tick();
      start = 1'b0;
      if (done) begin
        ndone++;
        check("ign_res", result, 25);
      end
    end
    check("ign_ndone", ndone, 1);

    // start held: one result every latency+1 cycles.
    x      = 16'd12;
    start  = 1'b1;
    per    = exp_lat(16'd12) + 1;
    ndone  = 0;
    last_t = -1;
    for (int c = 0; c < 3 * per + 2; c++) begin
      tick();
      if (done) begin
        check("held_res", result, 144);
        if (last_t >= 0) check("held_per", c - last_t, per);
        last_t = c;
        ndone++;
      end
    end
    start = 1'b0;
    check("held_ndone", ndone, 3);
    for (int c = 0; c < 3 * W && busy; c++) tick();
    check("held_drain", busy, 0);
    tick();

    // Asynchronous reset mid-computation.
    x     = 16'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_res", result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_one(16'd1000, "x1000");
    check("x1000_val", result, 1000000);

    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      rv = W'($urandom_range(0, 65535));
      run_one(rv, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
